// File: rtl/ibuf_pkg.sv
// Shared definitions for the instruction buffer: fetch exception codes and the
// per-entry record carried from fetch to decode.
package ibuf_pkg;

    typedef enum logic [3:0] {
        EXC_NONE = 4'd0,
        EXC_INT  = 4'd1,
        EXC_ADEF = 4'd2,
        EXC_TLBR = 4'd3,
        EXC_PIF  = 4'd4,
        EXC_PPI  = 4'd5,
        EXC_PIL  = 4'd6,
        EXC_PIS  = 4'd7,
        EXC_ADEM = 4'd8
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        excp;
        exception_t  excp_type;
    } ibuf_entry_t;

    function automatic ibuf_entry_t make_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        pred_taken,
        input logic [31:0] pred_target,
        input logic        excp,
        input exception_t  excp_type
    );
        ibuf_entry_t e;
        e.pc          = pc;
        e.inst        = inst;
        e.pred_taken  = pred_taken;
        e.pred_target = pred_target;
        e.excp        = excp;
        e.excp_type   = excp ? excp_type : EXC_NONE;
        return e;
    endfunction

endpackage

// File: rtl/ibuf.sv
// Instruction buffer: circular FIFO between fetch and decode, 2 pushes and
// 2 pops per cycle, flushed on redirect.
module ibuf
    import ibuf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [1:0]  ibuf_input_size,
    output logic        ibuf_ready,
    input  logic [31:0] pc1,
    input  logic [31:0] pc2,
    input  logic [31:0] inst1,
    input  logic [31:0] inst2,
    input  logic        pred_branch_taken1,
    input  logic        pred_branch_taken2,
    input  logic [31:0] pred_branch_target1,
    input  logic [31:0] pred_branch_target2,
    input  logic        have_exception,
    input  exception_t  exception_type,
    output logic        out_valid1,
    output logic        out_valid2,
    output ibuf_entry_t out_entry1,
    output ibuf_entry_t out_entry2,
    input  logic [1:0]  output_size
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ibuf_entry_t    r_mem [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic           r_alive;

    logic [PW-1:0]  w_head1;
    logic [PW-1:0]  w_tail1;
    logic [1:0]     w_push_n;
    logic [1:0]     w_pop_req;
    logic [1:0]     w_pop_n;
    logic           w_ready;
    ibuf_entry_t    w_slot1;
    ibuf_entry_t    w_slot2;

    assign w_head1 = r_head + 1'b1;
    assign w_tail1 = r_tail + 1'b1;

    // r_alive holds ready low through reset and releases it on the first clock after.
    always_comb begin
        w_ready    = r_alive && (r_count <= CW'(DEPTH - 2));
        ibuf_ready = w_ready;
        out_valid1 = (r_count != '0);
        out_valid2 = (r_count >= CW'(2));
        out_entry1 = r_mem[r_head];
        out_entry2 = r_mem[w_head1];
    end

    always_comb begin
        w_push_n = 2'd0;
        if (!flush && w_ready && ibuf_input_size != 2'd3)
            w_push_n = ibuf_input_size;
        w_pop_req = (output_size == 2'd3) ? 2'd2 : output_size;
        w_pop_n   = (CW'(w_pop_req) > r_count) ? r_count[1:0] : w_pop_req;
    end

    always_comb begin
        w_slot1 = make_entry(pc1, inst1, pred_branch_taken1, pred_branch_target1,
                             have_exception, exception_type);
        w_slot2 = make_entry(pc2, inst2, pred_branch_taken2, pred_branch_target2,
                             1'b0, EXC_NONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + PW'(w_pop_n);
                r_tail  <= r_tail + PW'(w_push_n);
                r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
            end
        end
    end

    // Storage is deliberately left unreset; valid is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push_n != 2'd0)
            r_mem[r_tail] <= w_slot1;
        if (w_push_n == 2'd2)
            r_mem[w_tail1] <= w_slot2;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            a_push_size : assert (ibuf_input_size != 2'd3);
            a_push_full : assert (ibuf_input_size == 2'd0 || w_ready);
            a_pop_size  : assert (output_size != 2'd3);
            a_pop_under : assert (CW'(output_size) <= r_count);
            a_exc_slot  : assert (!have_exception || ibuf_input_size != 2'd2);
        end
    end
`endif

endmodule
